pipe_adder_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-stage pipelined 16-bit adder (4-bit carry-select slices, no stall) among NUM_REQ requesters.
- Accepts at most one operand pair per cycle and drives it into the adder.
- Carries requester IDs through a tag pipeline matched to the adder latency, then returns sum/cout tagged with the originating requester.
- Provides a quiesce/drain handshake so software or a power controller can empty the adder safely.

---
 rtl/pipe_adder_pkg.sv | 21 ++
 rtl/pipe_adder_arbiter_if.sv | 28 ++
 rtl/pipe_tag_delay.sv | 39 +++
 rtl/pipe_adder_arbiter.sv | 153 +++++++++++++++
 tb/tb_pipe_adder_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared types and constants for the round-robin front end of the pipelined adder.
package pipe_adder_pkg;

    localparam int DATA_W      = 16;
    localparam int ADD_LATENCY = 4;
    localparam int MAX_REQ     = 8;
    localparam int TAG_ID_W    = $clog2(MAX_REQ);

    typedef logic [TAG_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    // Requester index reached by stepping 'offset' places past 'base', wrapping at n.
    function automatic int wrap_idx(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/pipe_adder_arbiter_if.sv
// Requester-side bundle: per-requester operand handshake plus the tagged result stream.
interface pipe_adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = pipe_adder_pkg::DATA_W
);
    localparam int SEL_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_cin;
    logic                      resp_valid;
    logic [SEL_W-1:0]          resp_id;
    logic [DATA_W-1:0]         resp_sum;
    logic                      resp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin,
        output req_ready, resp_valid, resp_id, resp_sum, resp_cout
    );

endinterface

// File: rtl/pipe_tag_delay.sv
// LATENCY-deep shift register of {valid, id} tags that tracks operations through the adder.
module pipe_tag_delay
    import pipe_adder_pkg::*;
#(
    parameter int LATENCY = ADD_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  tag_t din,
    output tag_t dout
);

    tag_t stage_reg [LATENCY];

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg[gi] <= '0;
                    end else begin
                        stage_reg[gi] <= din;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg[gi] <= '0;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign dout = stage_reg[LATENCY-1];

endmodule

// File: rtl/pipe_adder_arbiter.sv
// Round-robin sharing of one pipelined adder among NUM_REQ requesters, with tagged results and drain tracking.
// Optional registered response stage: define PIPE_ADDER_ARB_RESP_REG_EN.
module pipe_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = pipe_adder_pkg::ADD_LATENCY,
    parameter int DATA_W  = pipe_adder_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    pipe_adder_arbiter_if.slave           bus,
    output logic [DATA_W-1:0]             add_a,
    output logic [DATA_W-1:0]             add_b,
    output logic                          add_cin,
    input  logic [DATA_W-1:0]             add_sum,
    input  logic                          add_cout,
    input  logic                          quiesce,
    output logic                          idle,
    output logic [$clog2(LATENCY+2)-1:0]  inflight
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY+2);

    logic [DATA_W-1:0] op_a   [NUM_REQ];
    logic [DATA_W-1:0] op_b   [NUM_REQ];
    logic              op_cin [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_a[gi]   = bus.req_a[gi*DATA_W +: DATA_W];
            assign op_b[gi]   = bus.req_b[gi*DATA_W +: DATA_W];
            assign op_cin[gi] = bus.req_cin[gi];
        end
    endgenerate

    logic [SEL_W-1:0] rr_ptr_reg;
    logic [SEL_W-1:0] winner;
    logic             found;
    logic             issue;

    // Search starts just past the last grant so every requester gets a turn.
    always_comb begin
        winner = rr_ptr_reg;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && bus.req_valid[pipe_adder_pkg::wrap_idx(int'(rr_ptr_reg), k, NUM_REQ)]) begin
                found  = 1'b1;
                winner = SEL_W'(pipe_adder_pkg::wrap_idx(int'(rr_ptr_reg), k, NUM_REQ));
            end
        end
    end

    assign issue         = (|bus.req_valid) & ~quiesce;
    assign bus.req_ready = issue ? (NUM_REQ'(1) << winner) : '0;

    // Idle cycles push zeros so the adder pipeline carries deterministic bubbles.
    assign add_a   = issue ? op_a[winner]   : '0;
    assign add_b   = issue ? op_b[winner]   : '0;
    assign add_cin = issue ? op_cin[winner] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= SEL_W'(NUM_REQ-1);
        end else if (issue) begin
            rr_ptr_reg <= winner;
        end
    end

    pipe_adder_pkg::tag_t tag_in;
    pipe_adder_pkg::tag_t tag_out;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue;
        tag_in.id    = issue ? pipe_adder_pkg::req_id_t'(winner) : '0;
    end

    pipe_tag_delay #(
        .LATENCY (LATENCY)
    ) u_tag_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    logic             rsp_valid_c;
    logic [SEL_W-1:0] rsp_id_c;
    logic             retire;
    logic             unused_tag_bits;

    assign rsp_valid_c     = tag_out.valid;
    assign rsp_id_c        = tag_out.id[SEL_W-1:0];
    assign unused_tag_bits = ^tag_out.id;

`ifdef PIPE_ADDER_ARB_RESP_REG_EN
    logic              resp_valid_reg;
    logic [SEL_W-1:0]  resp_id_reg;
    logic [DATA_W-1:0] resp_sum_reg;
    logic              resp_cout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_sum_reg   <= '0;
            resp_cout_reg  <= 1'b0;
        end else begin
            resp_valid_reg <= rsp_valid_c;
            resp_id_reg    <= rsp_id_c;
            resp_sum_reg   <= add_sum;
            resp_cout_reg  <= add_cout;
        end
    end

    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_id    = resp_id_reg;
    assign bus.resp_sum   = resp_sum_reg;
    assign bus.resp_cout  = resp_cout_reg;
    assign retire         = resp_valid_reg;
`else
    assign bus.resp_valid = rsp_valid_c;
    assign bus.resp_id    = rsp_id_c;
    assign bus.resp_sum   = add_sum;
    assign bus.resp_cout  = add_cout;
    assign retire         = rsp_valid_c;
`endif

    logic [CNT_W-1:0] inflight_reg;
    logic [CNT_W-1:0] inflight_next;

    // An operation counts as in flight until the cycle its result is presented.
    always_comb begin
        inflight_next = inflight_reg;
        if (issue && !retire) begin
            inflight_next = inflight_reg + CNT_W'(1);
        end else if (!issue && retire) begin
            inflight_next = inflight_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
        end
    end

    assign inflight = inflight_reg;
    assign idle     = (inflight_reg == '0);

endmodule

// File: tb/tb_pipe_adder_arbiter.sv
// Directed bench for pipe_adder_arbiter with a behavioural 4-stage adder attached.
module tb_pipe_adder_arbiter;

`ifdef PIPE_ADDER_ARB_RESP_REG_EN
    localparam int RLAT = 5;
`else
    localparam int RLAT = 4;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        quiesce;
    logic        idle;
    logic [2:0]  inflight;

    pipe_adder_arbiter_if #(.NUM_REQ(4), .DATA_W(16)) bus ();

    pipe_adder_arbiter #(
        .NUM_REQ (4),
        .LATENCY (4),
        .DATA_W  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .quiesce  (quiesce),
        .idle     (idle),
        .inflight (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four-stage adder: operands captured on an edge appear four edges later.
    logic [16:0] add_pipe [4];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) add_pipe[k] <= '0;
        end else begin
            add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
            for (int k = 1; k < 4; k++) add_pipe[k] <= add_pipe[k-1];
        end
    end
    assign add_sum  = add_pipe[3][15:0];
    assign add_cout = add_pipe[3][16];

    typedef struct {
        int          issued;
        int          due;
        int          id;
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one cycle (grant, inflight/idle, response slot) then advances to the next negedge.
    task automatic step(input logic [3:0] exp_ready, input string tag);
        int n;
        #1;
        n = 0;
        foreach (expq[k]) if (expq[k].issued < cyc) n++;
        chk({tag, ".ready"}, {28'd0, bus.req_ready}, {28'd0, exp_ready});
        chk({tag, ".inflight"}, {29'd0, inflight}, n);
        chk({tag, ".idle"}, {31'd0, idle}, {31'd0, n == 0});
        if (expq.size() > 0 && expq[0].due == cyc) begin
            chk({tag, ".resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
            chk({tag, ".resp_id"}, {30'd0, bus.resp_id}, expq[0].id);
            chk({tag, ".resp_sum"}, {16'd0, bus.resp_sum}, {16'd0, expq[0].sum});
            chk({tag, ".resp_cout"}, {31'd0, bus.resp_cout}, {31'd0, expq[0].cout});
            $display("cyc=%0d %s resp id=%0d sum=%h cout=%0d", cyc, tag,
                     bus.resp_id, bus.resp_sum, bus.resp_cout);
            void'(expq.pop_front());
        end else begin
            chk({tag, ".resp_idle"}, {31'd0, bus.resp_valid}, 32'd0);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue_step(input int id, input logic [15:0] s, input logic c, input string tag);
        expq.push_back('{issued: cyc, due: cyc + RLAT, id: id, sum: s, cout: c});
        step(4'(1) << id, tag);
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
        bus.req_cin[i]        = c;
        bus.req_valid[i]      = 1'b1;
    endtask

    // Sums: 0001+0002=0003, 00FF+0001+1=0101, 8000+8000=1_0000, 1234+4321+1=5556.
    task automatic set_all();
        set_req(0, 16'h0001, 16'h0002, 1'b0);
        set_req(1, 16'h00FF, 16'h0001, 1'b1);
        set_req(2, 16'h8000, 16'h8000, 1'b0);
        set_req(3, 16'h1234, 16'h4321, 1'b1);
    endtask

    logic [15:0] sum_tab  [4];
    logic        cout_tab [4];

    initial begin
        sum_tab[0] = 16'h0003; cout_tab[0] = 1'b0;
        sum_tab[1] = 16'h0101; cout_tab[1] = 1'b0;
        sum_tab[2] = 16'h0000; cout_tab[2] = 1'b1;
        sum_tab[3] = 16'h5556; cout_tab[3] = 1'b0;

        rst           = 1'b1;
        quiesce       = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst.resp_id", {30'd0, bus.resp_id}, 32'd0);
        chk("rst.resp_sum", {16'd0, bus.resp_sum}, 32'd0);
        chk("rst.resp_cout", {31'd0, bus.resp_cout}, 32'd0);
        chk("rst.ready", {28'd0, bus.req_ready}, 32'd0);
        chk("rst.inflight", {29'd0, inflight}, 32'd0);
        chk("rst.idle", {31'd0, idle}, 32'd1);
        chk("rst.add_a", {16'd0, add_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        cyc = 0;

        // All four valid: grants 0,1,2,3 twice, responses in the same order
        set_all();
        for (int k = 0; k < 8; k++) issue_step(k % 4, sum_tab[k % 4], cout_tab[k % 4], "rr_all");
        bus.req_valid = '0;
        repeat (RLAT + 1) step(4'b0000, "rr_drain");

        // Single request from requester 0
        set_req(0, 16'h1234, 16'h0F0F, 1'b0);
        #1;
        chk("single.add_a", {16'd0, add_a}, 32'h1234);
        chk("single.add_b", {16'd0, add_b}, 32'h0F0F);
        chk("single.add_cin", {31'd0, add_cin}, 32'd0);
        issue_step(0, 16'h2143, 1'b0, "single");
        bus.req_valid = '0;
        repeat (RLAT + 1) step(4'b0000, "single_drain");

        // Overflow on requester 2: FFFF+0001+1 = 1_0001
        set_req(2, 16'hFFFF, 16'h0001, 1'b1);
        #1;
        chk("ovf.add_a", {16'd0, add_a}, 32'hFFFF);
        chk("ovf.add_cin", {31'd0, add_cin}, 32'd1);
        issue_step(2, 16'h0001, 1'b1, "overflow");
        bus.req_valid = '0;
        repeat (RLAT + 1) step(4'b0000, "ovf_drain");

        // Three issues, then quiesce while still requesting
        set_all();
        issue_step(3, 16'h5556, 1'b0, "pre_quiesce");
        issue_step(0, 16'h0003, 1'b0, "pre_quiesce");
        issue_step(1, 16'h0101, 1'b0, "pre_quiesce");
        quiesce = 1'b1;
        #1;
        chk("quiesce.add_a", {16'd0, add_a}, 32'd0);
        chk("quiesce.add_cin", {31'd0, add_cin}, 32'd0);
        repeat (RLAT + 1) step(4'b0000, "quiesce");
        quiesce = 1'b0;
        issue_step(2, 16'h0000, 1'b1, "resume");

        // Only requesters 1 and 3 active
        bus.req_valid = '0;
        set_req(1, 16'h00FF, 16'h0001, 1'b1);
        set_req(3, 16'h1234, 16'h4321, 1'b1);
        issue_step(3, 16'h5556, 1'b0, "alt");
        issue_step(1, 16'h0101, 1'b0, "alt");
        issue_step(3, 16'h5556, 1'b0, "alt");
        issue_step(1, 16'h0101, 1'b0, "alt");
        bus.req_valid = '0;
        repeat (RLAT + 1) step(4'b0000, "alt_drain");

        // Reset with three operations in flight
        set_all();
        issue_step(2, 16'h0000, 1'b1, "pre_rst");
        issue_step(3, 16'h5556, 1'b0, "pre_rst");
        issue_step(0, 16'h0003, 1'b0, "pre_rst");
        bus.req_valid = '0;
        rst = 1'b1;
        step(4'b0000, "rst_cycle");
        rst = 1'b0;
        expq.delete();
        repeat (RLAT + 2) step(4'b0000, "post_rst");
        set_all();
        issue_step(0, 16'h0003, 1'b0, "after_rst");
        bus.req_valid = '0;
        repeat (RLAT + 1) step(4'b0000, "final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
